// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Walks a 5-state FSM: REQUEST reads program memory at PC. WAIT captures the word
// that memory returns one cycle later and advances PC. ISSUE presents the word to the
// decoder until the decoder accepts it.
// Decoder handshake: InstructionValidOutput=1 means the opcode/mode/operand registers
// hold an instruction. The decoder takes it in any ISSUE cycle where StallInput=0.
// While StallInput=1 the registers and valid are held unchanged.
// Strobes are decoded from the state register, so an asynchronous reset clears them at once.
module instruction_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [4:0] HALT_OPCODE  = 5'b11111
) (
  input  logic        ClockInput,
  input  logic        ResetInput,
  input  logic        StartInput,
  input  logic        StallInput,
  input  logic        JumpFlagInput,
  input  logic [7:0]  JumpAddressInput,
  output logic [7:0]  ProgramAddressOutput,
  output logic        ProgramReadOutput,
  input  logic [21:0] ProgramDataInput,
  output logic [4:0]  OpecodeOutput,
  output logic        AddressingModeOutput,
  output logic [15:0] OperandOutput,
  output logic        InstructionValidOutput,
  output logic        HaltedOutput,
  output logic [2:0]  DebugStateOutput
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    WAIT    = 3'd2,
    ISSUE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  pc;
  logic [7:0]  pcNext;
  logic        latchWord;

  // Next-state, PC update and per-state strobes.
  always_comb begin
    stateNext              = state;
    pcNext                 = pc;
    latchWord              = 1'b0;
    ProgramReadOutput      = 1'b0;
    InstructionValidOutput = 1'b0;
    HaltedOutput           = 1'b0;
    case (state)
      IDLE: begin
        if (StartInput) stateNext = REQUEST;
      end
      REQUEST: begin
        ProgramReadOutput = 1'b1;
        stateNext         = WAIT;
      end
      WAIT: begin
        latchWord = 1'b1;
        pcNext    = pc + 8'd1;
        stateNext = ISSUE;
      end
      ISSUE: begin
        InstructionValidOutput = 1'b1;
        if (!StallInput) begin
          if (OpecodeOutput == HALT_OPCODE) begin
            stateNext = HALT;
          end else begin
            // A redirect replaces the PC that was already incremented in WAIT.
            if (JumpFlagInput) pcNext = JumpAddressInput;
            stateNext = REQUEST;
          end
        end
      end
      HALT: begin
        HaltedOutput = 1'b1;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, PC and decoder output registers; reset discards any in-flight word.
  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state                <= IDLE;
      pc                   <= RESET_VECTOR;
      OpecodeOutput        <= 5'd0;
      AddressingModeOutput <= 1'b0;
      OperandOutput        <= 16'd0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (latchWord) begin
        OpecodeOutput        <= ProgramDataInput[21:17];
        AddressingModeOutput <= ProgramDataInput[16];
        OperandOutput        <= ProgramDataInput[15:0];
      end
    end
  end

  // The address bus always shows PC.
  always_comb begin
    ProgramAddressOutput = pc;
    DebugStateOutput     = state;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch.
// The stimulus thread walks a directed program and pushes the expected fetch addresses
// and decoder words. A negedge monitor pops and compares them whenever the DUT strobes
// a read or raises valid.
module tb_instruction_fetch;

  localparam logic [21:0] W00  = {5'b00011, 1'b0, 16'h0005};
  localparam logic [21:0] W01  = {5'b00001, 1'b1, 16'hA5A5};
  localparam logic [21:0] W40  = {5'b00100, 1'b1, 16'h4040};
  localparam logic [21:0] W41  = {5'b00101, 1'b0, 16'h4141};
  localparam logic [21:0] WFF  = {5'b00111, 1'b1, 16'hFFFF};
  localparam logic [21:0] W10  = {5'b11111, 1'b1, 16'hDEAD};
  localparam logic [21:0] WMID = {5'b01010, 1'b1, 16'hBEEF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [7:0]  prog_addr;
  logic        prog_read;
  logic [21:0] prog_data = 22'd0;
  logic [4:0]  opcode;
  logic        addr_mode;
  logic [15:0] operand;
  logic        valid;
  logic        halted;
  logic [2:0]  dbg_state;

  logic [21:0] mem [256];
  logic [21:0] exp_q[$];
  logic [7:0]  addr_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  instruction_fetch dut (
    .ClockInput             (clk),
    .ResetInput             (rst),
    .StartInput             (start),
    .StallInput             (stall),
    .JumpFlagInput          (jump),
    .JumpAddressInput       (jump_addr),
    .ProgramAddressOutput   (prog_addr),
    .ProgramReadOutput      (prog_read),
    .ProgramDataInput       (prog_data),
    .OpecodeOutput          (opcode),
    .AddressingModeOutput   (addr_mode),
    .OperandOutput          (operand),
    .InstructionValidOutput (valid),
    .HaltedOutput           (halted),
    .DebugStateOutput       (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // program memory: word appears the cycle after the read strobe
  always @(posedge clk) begin
    if (prog_read) prog_data <= mem[prog_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " addr"},    {24'd0, prog_addr}, 32'h00);
    check({tag, " read"},    {31'd0, prog_read}, 32'd0);
    check({tag, " valid"},   {31'd0, valid},     32'd0);
    check({tag, " halted"},  {31'd0, halted},    32'd0);
    check({tag, " opcode"},  {27'd0, opcode},    32'd0);
    check({tag, " mode"},    {31'd0, addr_mode}, 32'd0);
    check({tag, " operand"}, {16'd0, operand},   32'd0);
    check({tag, " state"},   {29'd0, dbg_state}, 32'd0);
  endtask

  // scoreboard monitor: reads and newly valid instructions are popped from the queues
  initial begin : monitor
    logic prev_valid;
    logic [21:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (prog_read) begin
        if (addr_q.size() == 0) begin
          check("unexpected read addr", {24'd0, prog_addr}, 32'hFFFF_FFFF);
        end else begin
          check("read addr", {24'd0, prog_addr}, {24'd0, addr_q.pop_front()});
        end
      end
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected issue", {10'd0, opcode, addr_mode, operand}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("issued word", {10'd0, opcode, addr_mode, operand}, {10'd0, e});
        end
      end
      prev_valid = valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / stimulus
  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem[i] = 22'd0;
    mem[8'h00] = W00;
    mem[8'h01] = W01;
    mem[8'h40] = W40;
    mem[8'h41] = W41;
    mem[8'hFF] = WFF;
    mem[8'h10] = W10;

    // reset state, then idle until start
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("idle read", {31'd0, prog_read}, 32'd0);
      check("idle state", {29'd0, dbg_state}, 32'd0);
    end

    // first fetch from 00, then a 4-cycle stall in ISSUE
    addr_q.push_back(8'h00);
    exp_q.push_back(W00);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("request read", {31'd0, prog_read}, 32'd1);
    tick();
    check("wait read", {31'd0, prog_read}, 32'd0);
    check("wait addr", {24'd0, prog_addr}, 32'h00);
    stall = 1'b1;
    tick();
    check("issue valid", {31'd0, valid}, 32'd1);
    check("issue addr", {24'd0, prog_addr}, 32'h01);
    repeat (4) begin
      tick();
      check("stall valid", {31'd0, valid}, 32'd1);
      check("stall read", {31'd0, prog_read}, 32'd0);
      check("stall word", {10'd0, opcode, addr_mode, operand}, {10'd0, W00});
    end
    stall = 1'b0;
    addr_q.push_back(8'h01);
    exp_q.push_back(W01);
    tick();
    check("post stall read", {31'd0, prog_read}, 32'd1);

    // jump during WAIT is ignored; jump in ISSUE redirects to 40
    tick();
    jump = 1'b1;
    jump_addr = 8'h80;
    tick();
    check("jump ignored addr", {24'd0, prog_addr}, 32'h02);
    jump_addr = 8'h40;
    addr_q.push_back(8'h40);
    exp_q.push_back(W40);
    tick();
    jump = 1'b0;
    check("jump target", {24'd0, prog_addr}, 32'h40);

    // sequential to 41, then jump to FF
    addr_q.push_back(8'h41);
    exp_q.push_back(W41);
    tick();
    tick();
    tick();
    check("sequential addr", {24'd0, prog_addr}, 32'h41);
    tick();
    tick();
    jump = 1'b1;
    jump_addr = 8'hFF;
    addr_q.push_back(8'hFF);
    exp_q.push_back(WFF);
    tick();
    jump = 1'b0;
    check("jump ff", {24'd0, prog_addr}, 32'hFF);

    // PC wraps from FF to 00; start pulse mid-flow does nothing
    tick();
    tick();
    check("wrap addr", {24'd0, prog_addr}, 32'h00);
    addr_q.push_back(8'h00);
    exp_q.push_back(W00);
    tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    jump = 1'b1;
    jump_addr = 8'h10;
    addr_q.push_back(8'h10);
    exp_q.push_back(W10);
    tick();
    jump = 1'b0;

    // halt word: jump asserted in its ISSUE is ignored
    tick();
    tick();
    check("halt word opcode", {27'd0, opcode}, 32'h1F);
    jump = 1'b1;
    jump_addr = 8'h55;
    tick();
    jump = 1'b0;
    check("halted", {31'd0, halted}, 32'd1);
    check("halt valid", {31'd0, valid}, 32'd0);
    check("halt addr", {24'd0, prog_addr}, 32'h11);
    start = 1'b1;
    repeat (4) begin
      tick();
      check("halt stays", {31'd0, halted}, 32'd1);
      check("halt no read", {31'd0, prog_read}, 32'd0);
      check("halt keeps word", {10'd0, opcode, addr_mode, operand}, {10'd0, W10});
    end
    start = 1'b0;

    // asynchronous reset out of HALT
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("halt reset");
    #1;
    rst = 1'b0;
    repeat (2) begin
      tick();
      check("post reset idle", {29'd0, dbg_state}, 32'd0);
      check("post reset no read", {31'd0, prog_read}, 32'd0);
    end

    // reset mid-WAIT: the in-flight word must never issue
    mem[8'h00] = WMID;
    addr_q.push_back(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid wait state", {29'd0, dbg_state}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid wait reset");
    #1;
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("discarded valid", {31'd0, valid}, 32'd0);
      check("discarded opcode", {27'd0, opcode}, 32'd0);
    end

    check("exp queue drained", exp_q.size(), 32'd0);
    check("addr queue drained", addr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
